sparrow_lsu: RTL and testbench

Load/store unit: the initiator side of the core's data-memory interface. It accepts one memory op at a time from the execute stage and checks alignment. It drives the dmem request/address/size/write signals, then extracts and sign/zero-extends load data from the returned word. It returns a single-cycle result to writeback and flags misaligned accesses to the trap logic.

---
 rtl/sparrow_lsu.sv | 159 +++++++++++++++
 tb/tb_sparrow_lsu.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sparrow_lsu.sv
// Load/store unit: single outstanding dmem op with alignment check, optional
// request wait states, load lane extraction/extension and a one-cycle result pulse.
module sparrow_lsu #(
    parameter int unsigned RD_WAIT = 0
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_is_store,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wr_data,
    input  logic [4:0]  i_rd,
    input  logic        i_flush,
    output logic        o_valid,
    output logic [31:0] o_rd_data,
    output logic [4:0]  o_rd,
    output logic        o_is_store,
    output logic        o_misaligned,
    output logic [31:0] o_fault_addr,
    output logic        o_dmem_req,
    output logic [31:0] o_dmem_addr,
    output logic [1:0]  o_dmem_byte_en,
    output logic        o_dmem_wr_en,
    output logic [31:0] o_dmem_wr_data,
    input  logic [31:0] i_dmem_rd_data
);

    localparam logic [1:0] BYTE      = 2'd0;
    localparam logic [1:0] HALF_WORD = 2'd1;
    localparam logic [1:0] WORD      = 2'd2;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_is_store;
    logic        r_unsigned;
    logic [4:0]  r_rd;
    logic        r_valid;
    logic [31:0] r_rd_data;
    logic        r_mis;
    logic [31:0] r_fault;
    logic        r_req;
    logic [31:0] r_addr;
    logic [1:0]  r_byte_en;
    logic        r_wr_en;
    logic [31:0] r_wr_data;

    logic        w_misaligned;
    logic        w_accept;

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic uns, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            BYTE:      return uns ? {24'd0, b} : {{24{b[7]}}, b};
            HALF_WORD: return uns ? {16'd0, h} : {{16{h[15]}}, h};
            default:   return word;
        endcase
    endfunction

    assign w_misaligned = ((i_size == HALF_WORD) && i_addr[0]) ||
                          ((i_size == WORD) && (i_addr[1:0] != 2'b00));
    assign o_ready      = i_reset_n && (r_state == IDLE) && !i_flush;
    assign w_accept     = i_valid && o_ready;

    // A store that reached DONE has already written memory, so flush cannot hide it.
    assign o_valid        = r_valid && (!i_flush || (r_is_store && !r_mis));
    assign o_rd_data      = r_rd_data;
    assign o_rd           = r_rd;
    assign o_is_store     = r_is_store;
    assign o_misaligned   = r_mis;
    assign o_fault_addr   = r_fault;
    assign o_dmem_req     = r_req;
    assign o_dmem_addr    = r_addr;
    assign o_dmem_byte_en = r_byte_en;
    assign o_dmem_wr_en   = r_wr_en;
    assign o_dmem_wr_data = r_wr_data;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_is_store <= 1'b0;
            r_unsigned <= 1'b0;
            r_rd       <= '0;
            r_valid    <= 1'b0;
            r_rd_data  <= '0;
            r_mis      <= 1'b0;
            r_fault    <= '0;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_byte_en  <= '0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_is_store <= i_is_store;
                        r_unsigned <= i_unsigned;
                        r_rd       <= i_rd;
                        if (w_misaligned) begin
                            r_state   <= DONE;
                            r_valid   <= 1'b1;
                            r_mis     <= 1'b1;
                            r_fault   <= i_addr;
                            r_rd_data <= '0;
                        end else begin
                            r_state   <= REQ;
                            r_cnt     <= 4'(RD_WAIT);
                            r_req     <= 1'b1;
                            r_addr    <= i_addr;
                            r_byte_en <= i_size;
                            r_wr_data <= i_wr_data;
                            r_wr_en   <= i_is_store && (RD_WAIT == 0);
                        end
                    end
                end
                REQ: begin
                    if (i_flush && !r_is_store) begin
                        r_state   <= IDLE;
                        r_req     <= 1'b0;
                        r_addr    <= '0;
                        r_byte_en <= '0;
                        r_wr_en   <= 1'b0;
                        r_wr_data <= '0;
                    end else if (r_cnt == 4'd0) begin
                        r_state   <= DONE;
                        r_valid   <= 1'b1;
                        r_mis     <= 1'b0;
                        r_fault   <= '0;
                        r_rd_data <= r_is_store ? '0
                                   : extract(i_dmem_rd_data, r_byte_en, r_unsigned, r_addr[1:0]);
                        r_req     <= 1'b0;
                        r_addr    <= '0;
                        r_byte_en <= '0;
                        r_wr_en   <= 1'b0;
                        r_wr_data <= '0;
                    end else begin
                        r_cnt   <= r_cnt - 4'd1;
                        r_wr_en <= r_is_store && (r_cnt == 4'd1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sparrow_lsu.sv
// Scoreboard bench: two LSUs (RD_WAIT 0 and 3) share stimulus; expected results are
// queued at issue and popped by a monitor whenever a DUT pulses o_valid.
module tb_sparrow_lsu;

    localparam logic [1:0] BYTE      = 2'd0;
    localparam logic [1:0] HALF_WORD = 2'd1;
    localparam logic [1:0] WORD      = 2'd2;
    localparam int W0 = 0;
    localparam int W1 = 3;

    typedef struct {
        logic [4:0]  rd;
        logic        st;
        logic        mis;
        logic [31:0] data;
        logic [31:0] fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid = 1'b0;
    logic        is_store = 1'b0;
    logic [1:0]  size = '0;
    logic        uns = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wr_data = '0;
    logic [4:0]  rd = '0;
    logic        flush = 1'b0;

    logic        rdy [2];
    logic        ov [2];
    logic [31:0] ordata [2];
    logic [4:0]  ord [2];
    logic        ost [2];
    logic        omis [2];
    logic [31:0] ofault [2];
    logic        req [2];
    logic [31:0] daddr [2];
    logic [1:0]  dben [2];
    logic        dwe [2];
    logic [31:0] dwd [2];
    logic [31:0] drd [2];

    logic [31:0] mem [256];
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t e;
    int checks = 0;
    int failures = 0;
    int reqcnt [2];
    int wrcnt [2];
    logic        cur_st;
    logic [31:0] cur_addr;
    logic [1:0]  cur_size;
    logic [31:0] cur_wd;

    always #5 clk = ~clk;

    assign drd[0] = mem[daddr[0][9:2]];
    assign drd[1] = mem[daddr[1][9:2]];

    sparrow_lsu #(.RD_WAIT(W0)) u_lsu0 (
        .i_clk(clk), .i_reset_n(reset_n), .i_valid(valid), .o_ready(rdy[0]),
        .i_is_store(is_store), .i_size(size), .i_unsigned(uns), .i_addr(addr),
        .i_wr_data(wr_data), .i_rd(rd), .i_flush(flush), .o_valid(ov[0]),
        .o_rd_data(ordata[0]), .o_rd(ord[0]), .o_is_store(ost[0]),
        .o_misaligned(omis[0]), .o_fault_addr(ofault[0]), .o_dmem_req(req[0]),
        .o_dmem_addr(daddr[0]), .o_dmem_byte_en(dben[0]), .o_dmem_wr_en(dwe[0]),
        .o_dmem_wr_data(dwd[0]), .i_dmem_rd_data(drd[0])
    );

    sparrow_lsu #(.RD_WAIT(W1)) u_lsu1 (
        .i_clk(clk), .i_reset_n(reset_n), .i_valid(valid), .o_ready(rdy[1]),
        .i_is_store(is_store), .i_size(size), .i_unsigned(uns), .i_addr(addr),
        .i_wr_data(wr_data), .i_rd(rd), .i_flush(flush), .o_valid(ov[1]),
        .o_rd_data(ordata[1]), .o_rd(ord[1]), .o_is_store(ost[1]),
        .o_misaligned(omis[1]), .o_fault_addr(ofault[1]), .o_dmem_req(req[1]),
        .o_dmem_addr(daddr[1]), .o_dmem_byte_en(dben[1]), .o_dmem_wr_en(dwe[1]),
        .o_dmem_wr_data(dwd[1]), .i_dmem_rd_data(drd[1])
    );

    function automatic int waitof(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    function automatic void chk(input string name, input int d,
                                input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, d, $time, act, exp);
        end
    endfunction

    // Reference load result from the byte-lane rules using plain arithmetic.
    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                               input bit u, input logic [31:0] a);
        longint v;
        if (sz == BYTE) begin
            v = (longint'(word) >> (8 * (a % 4))) % 256;
            if (!u && v >= 128) v = v - 256;
        end else if (sz == HALF_WORD) begin
            v = (longint'(word) >> (16 * ((a / 2) % 2))) % 65536;
            if (!u && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(word);
        end
        return v[31:0];
    endfunction

    task automatic chk_zero(input int d);
        chk("reset_result_zero", d, {ov[d], ordata[d], ord[d], ost[d], omis[d], ofault[d]}, '0);
        chk("reset_dmem_zero", d, {req[d], daddr[d], dben[d], dwe[d], dwd[d]}, '0);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ov[d]) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    chk("unexpected_valid", d, 1, 0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk("o_rd", d, ord[d], e.rd);
                    chk("o_is_store", d, ost[d], e.st);
                    chk("o_misaligned", d, omis[d], e.mis);
                    chk("o_rd_data", d, ordata[d], e.data);
                    chk("o_fault_addr", d, ofault[d], e.fault);
                end
            end
            if (req[d]) begin
                reqcnt[d]++;
                chk("dmem_addr", d, daddr[d], cur_addr);
                chk("dmem_byte_en", d, dben[d], cur_size);
                chk("dmem_wr_data", d, dwd[d], cur_wd);
                chk("dmem_wr_en", d, dwe[d], cur_st && (reqcnt[d] == waitof(d) + 1));
                if (dwe[d]) wrcnt[d]++;
            end else begin
                chk("dmem_idle_zero", d, {daddr[d], dben[d], dwe[d], dwd[d]}, '0);
            end
        end
    end

    // fk: cycle after accept carrying i_flush (0=none); rk: cycle carrying reset (0=none).
    task automatic issue(input bit st, input logic [1:0] sz, input bit u, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] r, input int fk, input int rk);
        bit   mis;
        exp_t x;
        int   busy [2];
        int   ereq [2];
        int   ewr;
        int   lat;
        bit   exp_rdy;
        mis = (sz == HALF_WORD && a % 2 != 0) || (sz == WORD && a % 4 != 0);
        x.rd = r;
        x.st = st;
        x.mis = mis;
        x.fault = mis ? a : 32'd0;
        x.data = (st || mis) ? 32'd0 : model_load(mem[a[9:2]], sz, u, a);
        ewr = (!mis && st && rk == 0) ? 1 : 0;
        for (int d = 0; d < 2; d++) begin
            lat = mis ? 1 : waitof(d) + 2;
            if (mis) begin
                busy[d] = 1; ereq[d] = 0;
            end else if (rk > 0) begin
                busy[d] = rk; ereq[d] = rk;
            end else if (!st && fk > 0 && fk <= waitof(d) + 1) begin
                busy[d] = fk; ereq[d] = fk;
            end else begin
                busy[d] = waitof(d) + 2; ereq[d] = waitof(d) + 1;
            end
            if (rk == 0 && !(fk > 0 && fk <= lat && !(st && !mis))) begin
                if (d == 0) q0.push_back(x);
                else q1.push_back(x);
            end
        end
        @(posedge clk);
        #1;
        cur_st = st; cur_addr = a; cur_size = sz; cur_wd = wd;
        reqcnt[0] = 0; reqcnt[1] = 0; wrcnt[0] = 0; wrcnt[1] = 0;
        valid = 1'b1; is_store = st; size = sz; uns = u; addr = a; wr_data = wd; rd = r;
        flush = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("ready_at_issue", d, rdy[d], 1);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            valid = 1'b0;
            flush = (k == fk);
            reset_n = !(rk > 0 && k == rk);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rk > 0 && k >= rk) exp_rdy = (k != rk);
                else exp_rdy = (k > busy[d]) && (k != fk);
                chk("o_ready", d, rdy[d], exp_rdy);
                if (rk > 0 && k == rk + 1) chk_zero(d);
            end
        end
        for (int d = 0; d < 2; d++) begin
            chk("req_cycles", d, reqcnt[d], ereq[d]);
            chk("wr_cycles", d, wrcnt[d], ewr);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'h40] = 32'h80FF_1234;
        cur_st = 1'b0; cur_addr = '0; cur_size = '0; cur_wd = '0;
        reqcnt[0] = 0; reqcnt[1] = 0; wrcnt[0] = 0; wrcnt[1] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("ready_in_reset", d, rdy[d], 0);
            chk_zero(d);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;

        issue(0, BYTE, 0, 32'h103, 32'h0, 5'd1, 0, 0);
        issue(0, BYTE, 1, 32'h103, 32'h0, 5'd2, 0, 0);
        issue(1, HALF_WORD, 0, 32'h202, 32'h0000_BEEF, 5'd3, 0, 0);
        issue(0, WORD, 0, 32'h206, 32'h0, 5'd4, 0, 0);
        issue(1, HALF_WORD, 0, 32'h201, 32'h1234, 5'd5, 0, 0);
        issue(0, WORD, 0, 32'h40, 32'h0, 5'd6, 0, 0);
        issue(0, WORD, 0, 32'h40, 32'h0, 5'd7, 2, 0);
        issue(1, WORD, 0, 32'h44, 32'hCAFE_F00D, 5'd8, 2, 0);
        issue(0, WORD, 0, 32'h48, 32'h0, 5'd9, 0, 1);
        issue(0, WORD, 0, 32'h0, 32'h0, 5'd10, 0, 0);

        for (int n = 0; n < 200; n++) begin
            issue(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), bit'($urandom_range(0, 1)),
                  32'($urandom_range(0, 1023)), $urandom, 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0, 0);
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", 0, q0.size(), 0);
        chk("queue_drained", 1, q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
